victim_refill_ctrl: RTL and testbench

// Sequences an L1 line miss against the victim cache and main memory.
// - Accepts one miss at a time from the L1 cache.
// - Probes the victim cache first. On a hit, it refills the L1 from the victim line.
//   On a miss, it fetches the line from memory in LINE_SIZE word beats.
// - Refills the L1, and in the same cycle writes the evicted L1 line into the victim cache.
// - Sits between the L1 cache controller, the victim cache port and the memory request/response port.

---
 rtl/victim_refill_ctrl.sv | 175 +++++++++++++++++
 tb/tb_victim_refill_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_refill_ctrl.sv
// Miss sequencer: probes the victim cache, falls back to a beat-wise memory
// fetch, refills L1 and retires the evicted line into the victim cache.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module victim_refill_ctrl #(
    parameter int BLOCK_OFFSET_WIDTH = 2,
    parameter int CNT_WIDTH          = 32,
    localparam int LINE = 1 << BLOCK_OFFSET_WIDTH,
    localparam int LA   = `ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2,
    localparam int DW   = `DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_miss_valid,
    output logic                     o_miss_ready,
    input  logic [LA-1:0]            i_miss_addr,
    input  logic                     i_evict_valid,
    input  logic [LA-1:0]            i_evict_addr,
    input  logic [LINE-1:0][DW-1:0]  i_evict_data,
    output logic [LA-1:0]            o_vc_raddr,
    input  logic                     i_vc_hit,
    input  logic [LINE-1:0][DW-1:0]  i_vc_rdata,
    output logic                     o_vc_we,
    output logic [LA-1:0]            o_vc_waddr,
    output logic [LINE-1:0][DW-1:0]  o_vc_wdata,
    output logic                     o_mem_req_valid,
    input  logic                     i_mem_req_ready,
    output logic [LA-1:0]            o_mem_req_addr,
    input  logic                     i_mem_data_valid,
    input  logic [DW-1:0]            i_mem_data,
    output logic                     o_fill_valid,
    input  logic                     i_fill_ready,
    output logic [LA-1:0]            o_fill_addr,
    output logic [LINE-1:0][DW-1:0]  o_fill_data,
    output logic                     o_fill_from_vc,
    output logic                     o_busy,
    output logic [CNT_WIDTH-1:0]     o_hit_count,
    output logic [CNT_WIDTH-1:0]     o_miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_MEM_REQ,
        S_MEM_DATA,
        S_FILL
    } state_t;

    localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_BEAT =
        BLOCK_OFFSET_WIDTH'(LINE - 1);

    state_t                          state_q;
    logic                            busy_q;
    logic                            req_q;
    logic                            fill_q;
    logic                            from_vc_q;
    logic                            evict_pend_q;
    logic [LA-1:0]                   miss_addr_q;
    logic [LA-1:0]                   evict_addr_q;
    logic [LINE-1:0][DW-1:0]         evict_data_q;
    logic [LINE-1:0][DW-1:0]         line_q;
    logic [BLOCK_OFFSET_WIDTH-1:0]   beat_q;
    logic [CNT_WIDTH-1:0]            hit_cnt_q;
    logic [CNT_WIDTH-1:0]            hit_cnt_d;
    logic [CNT_WIDTH-1:0]            miss_cnt_q;
    logic [CNT_WIDTH-1:0]            miss_cnt_d;

    // Saturating increments: hold at all-ones instead of wrapping.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            req_q        <= 1'b0;
            fill_q       <= 1'b0;
            from_vc_q    <= 1'b0;
            evict_pend_q <= 1'b0;
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            line_q       <= '0;
            beat_q       <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_miss_valid) begin
                        miss_addr_q  <= i_miss_addr;
                        evict_addr_q <= i_evict_addr;
                        evict_data_q <= i_evict_data;
                        evict_pend_q <= i_evict_valid &&
                                        (i_evict_addr != i_miss_addr);
                        from_vc_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (i_vc_hit) begin
                        line_q    <= i_vc_rdata;
                        from_vc_q <= 1'b1;
                        hit_cnt_q <= hit_cnt_d;
                        fill_q    <= 1'b1;
                        state_q   <= S_FILL;
                    end else begin
                        miss_cnt_q <= miss_cnt_d;
                        req_q      <= 1'b1;
                        state_q    <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (i_mem_req_ready) begin
                        beat_q  <= '0;
                        req_q   <= 1'b0;
                        state_q <= S_MEM_DATA;
                    end
                end
                S_MEM_DATA: begin
                    if (i_mem_data_valid) begin
                        line_q[beat_q] <= i_mem_data;
                        beat_q         <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            fill_q  <= 1'b1;
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (i_fill_ready) begin
                        fill_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        evict_pend_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The VC write rides on the fill handshake so both retire together.
    assign o_vc_we         = fill_q && i_fill_ready && evict_pend_q;
    assign o_vc_waddr      = evict_addr_q;
    assign o_vc_wdata      = evict_data_q;
    assign o_miss_ready    = !busy_q;
    assign o_busy          = busy_q;
    assign o_vc_raddr      = miss_addr_q;
    assign o_mem_req_valid = req_q;
    assign o_mem_req_addr  = miss_addr_q;
    assign o_fill_valid    = fill_q;
    assign o_fill_addr     = miss_addr_q;
    assign o_fill_data     = line_q;
    assign o_fill_from_vc  = from_vc_q;
    assign o_hit_count     = hit_cnt_q;
    assign o_miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_victim_refill_ctrl.sv
// Randomized bench for victim_refill_ctrl against a transaction-level model.
// Built with a 4-bit counter so saturation is reachable.
module tb_victim_refill_ctrl;

    localparam int LINE = 4;
    localparam int DW   = 32;
    localparam int LA   = 28;
    localparam int CW   = 4;

    typedef logic [LINE-1:0][DW-1:0] line_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_miss_valid = 1'b0;
    logic            o_miss_ready;
    logic [LA-1:0]   i_miss_addr = '0;
    logic            i_evict_valid = 1'b0;
    logic [LA-1:0]   i_evict_addr = '0;
    line_t           i_evict_data = '0;
    logic [LA-1:0]   o_vc_raddr;
    logic            i_vc_hit = 1'b0;
    line_t           i_vc_rdata = '0;
    logic            o_vc_we;
    logic [LA-1:0]   o_vc_waddr;
    line_t           o_vc_wdata;
    logic            o_mem_req_valid;
    logic            i_mem_req_ready = 1'b0;
    logic [LA-1:0]   o_mem_req_addr;
    logic            i_mem_data_valid = 1'b0;
    logic [DW-1:0]   i_mem_data = '0;
    logic            o_fill_valid;
    logic            i_fill_ready = 1'b0;
    logic [LA-1:0]   o_fill_addr;
    line_t           o_fill_data;
    logic            o_fill_from_vc;
    logic            o_busy;
    logic [CW-1:0]   o_hit_count;
    logic [CW-1:0]   o_miss_count;

    victim_refill_ctrl #(
        .BLOCK_OFFSET_WIDTH (2),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_miss_valid     (i_miss_valid),
        .o_miss_ready     (o_miss_ready),
        .i_miss_addr      (i_miss_addr),
        .i_evict_valid    (i_evict_valid),
        .i_evict_addr     (i_evict_addr),
        .i_evict_data     (i_evict_data),
        .o_vc_raddr       (o_vc_raddr),
        .i_vc_hit         (i_vc_hit),
        .i_vc_rdata       (i_vc_rdata),
        .o_vc_we          (o_vc_we),
        .o_vc_waddr       (o_vc_waddr),
        .o_vc_wdata       (o_vc_wdata),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_data_valid (i_mem_data_valid),
        .i_mem_data       (i_mem_data),
        .o_fill_valid     (o_fill_valid),
        .i_fill_ready     (i_fill_ready),
        .o_fill_addr      (o_fill_addr),
        .o_fill_data      (o_fill_data),
        .o_fill_from_vc   (o_fill_from_vc),
        .o_busy           (o_busy),
        .o_hit_count      (o_hit_count),
        .o_miss_count     (o_miss_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int hit_m  = 0;
    int miss_m = 0;
    int we_cnt = 0;
    int req_cnt = 0;

    always @(posedge clk) begin
        if (o_vc_we) we_cnt++;
        if (o_mem_req_valid && i_mem_req_ready) req_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic int sat(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    function automatic line_t rnd_line();
        line_t l;
        for (int w = 0; w < LINE; w++) l[w] = $urandom;
        return l;
    endfunction

    function automatic logic [LA-1:0] rnd_addr();
        return LA'($urandom);
    endfunction

    task automatic idle_checks();
        chk("cnt_hit", o_hit_count, sat(hit_m));
        chk("cnt_miss", o_miss_count, sat(miss_m));
        chk("idle_ready", o_miss_ready, 1);
        chk("idle_busy", o_busy, 0);
        chk("idle_fill", o_fill_valid, 0);
    endtask

    task automatic run_miss(input logic [LA-1:0] a, input bit ev,
                            input logic [LA-1:0] ea, input line_t ed,
                            input bit hit, input line_t vd, input line_t md,
                            input int req_dly, input int gap,
                            input int fill_dly);
        int    we0;
        int    rq0;
        bit    pend;
        line_t exp_line;
        we0      = we_cnt;
        rq0      = req_cnt;
        pend     = ev && (ea != a);
        exp_line = hit ? vd : md;
        chk("accept_ready", o_miss_ready, 1);
        i_miss_valid  = 1'b1;
        i_miss_addr   = a;
        i_evict_valid = ev;
        i_evict_addr  = ea;
        i_evict_data  = ed;
        @(negedge clk);
        i_miss_valid  = 1'b0;
        i_miss_addr   = rnd_addr();
        i_evict_valid = 1'b1;
        i_evict_addr  = rnd_addr();
        i_evict_data  = rnd_line();
        chk("probe_addr", o_vc_raddr, a);
        chk("probe_ready", o_miss_ready, 0);
        i_vc_hit   = hit;
        i_vc_rdata = vd;
        @(negedge clk);
        i_vc_hit   = 1'b0;
        i_vc_rdata = rnd_line();
        if (hit) begin
            hit_m++;
        end else begin
            miss_m++;
            i_mem_data_valid = 1'b1;
            i_mem_data       = 32'hDEAD_BEEF;
            repeat (req_dly) begin
                chk("req_valid", o_mem_req_valid, 1);
                chk("req_addr", o_mem_req_addr, a);
                @(negedge clk);
            end
            i_mem_req_ready = 1'b1;
            @(negedge clk);
            i_mem_req_ready  = 1'b0;
            i_mem_data_valid = 1'b0;
            for (int b = 0; b < LINE; b++) begin
                repeat (gap) @(negedge clk);
                i_mem_data_valid = 1'b1;
                i_mem_data       = md[b];
                @(negedge clk);
                i_mem_data_valid = 1'b0;
            end
        end
        chk("fill_valid", o_fill_valid, 1);
        repeat (fill_dly) begin
            i_miss_valid = 1'b1;
            i_miss_addr  = ~a;
            chk("hold_data", o_fill_data, exp_line);
            chk("hold_addr", o_fill_addr, a);
            chk("hold_we", o_vc_we, 0);
            chk("hold_ready", o_miss_ready, 0);
            @(negedge clk);
        end
        i_miss_valid = 1'b0;
        chk("fill_data", o_fill_data, exp_line);
        chk("fill_addr", o_fill_addr, a);
        chk("fill_vc", o_fill_from_vc, hit);
        i_fill_ready = 1'b1;
        #1;
        chk("vc_we", o_vc_we, pend);
        if (pend) begin
            chk("vc_waddr", o_vc_waddr, ea);
            chk("vc_wdata", o_vc_wdata, ed);
        end
        @(negedge clk);
        i_fill_ready = 1'b0;
        chk("we_pulses", we_cnt - we0, pend ? 1 : 0);
        chk("req_hs", req_cnt - rq0, hit ? 0 : 1);
        idle_checks();
    endtask

    initial begin
        line_t mline;
        logic [LA-1:0] a;
        int we0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_miss_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_req", o_mem_req_valid, 0);
        chk("rst_fill", o_fill_valid, 0);
        chk("rst_we", o_vc_we, 0);
        chk("rst_raddr", o_vc_raddr, 0);
        chk("rst_hits", o_hit_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_miss(28'h0000010, 1, 28'h0000020, rnd_line(), 1, rnd_line(),
                 '0, 0, 0, 0);
        for (int w = 0; w < LINE; w++) mline[w] = 32'hA0 + w;
        run_miss(rnd_addr(), 1, rnd_addr(), rnd_line(), 0, rnd_line(),
                 mline, 3, 1, 0);
        run_miss(28'h0000100, 0, 28'h0000200, rnd_line(), 0, rnd_line(),
                 rnd_line(), 1, 0, 0);
        run_miss(28'h0000300, 1, 28'h0000300, rnd_line(), 1, rnd_line(),
                 '0, 0, 0, 0);
        run_miss(rnd_addr(), 1, rnd_addr(), rnd_line(), 1, rnd_line(),
                 '0, 0, 0, 5);
        run_miss(rnd_addr(), 1, rnd_addr(), rnd_line(), 0, rnd_line(),
                 rnd_line(), 0, 0, 5);

        // Abort mid-fetch after two beats.
        we0 = we_cnt;
        a   = rnd_addr();
        i_miss_valid  = 1'b1;
        i_miss_addr   = a;
        i_evict_valid = 1'b1;
        i_evict_addr  = rnd_addr();
        @(negedge clk);
        i_miss_valid  = 1'b0;
        @(negedge clk);
        i_mem_req_ready = 1'b1;
        @(negedge clk);
        i_mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            i_mem_data_valid = 1'b1;
            i_mem_data       = $urandom;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        hit_m  = 0;
        miss_m = 0;
        idle_checks();
        chk("rst_req_mid", o_mem_req_valid, 0);
        @(negedge clk);
        i_mem_data_valid = 1'b0;
        rst_n = 1'b1;
        chk("rst_no_we", we_cnt - we0, 0);
        run_miss(a, 1, rnd_addr(), rnd_line(), 0, rnd_line(),
                 rnd_line(), 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            logic [LA-1:0] ra;
            logic [LA-1:0] re;
            ra = rnd_addr();
            re = ($urandom_range(0, 3) == 0) ? ra : rnd_addr();
            run_miss(ra, 1'($urandom), re, rnd_line(), 1'($urandom),
                     rnd_line(), rnd_line(), $urandom_range(0, 3),
                     $urandom_range(0, 2), $urandom_range(0, 3));
        end

        for (int t = 0; t < 20; t++) begin
            run_miss(rnd_addr(), 1, rnd_addr(), rnd_line(), 1, rnd_line(),
                     '0, 0, 0, 0);
        end
        chk("hit_sat", o_hit_count, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
